mc_ctrl: RTL
============

// Module: mc_ctrl
// PURPOSE
//   Multi-cycle sequencer for the RV32I datapath: steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
//   Drives ALU operand selects, PC/IR/regfile write enables and the imem/dmem request handshakes.
//   Sits beside alu; the PC mux (PC+4 vs o_JumpBranchAddr_32) is steered by o_PCSel.
//   Counts retired instructions; traps on illegal opcode or memory timeout.
// PARAMETERS
//   MEM_TIMEOUT  16  max wait cycles on imem/dmem ready before bus-error trap (>=2)
//   CNT_W        32  width of the retired-instruction counter
// PORTS
//   clk              in   1      clock, rising edge
//   rst              in   1      asynchronous reset, active-high
//   i_Inst_32        in   32     current IR contents (valid from DECODE onward)
//   i_BranchTaken    in   1      branch compare result from datapath, valid in EXEC
//   i_ImemReady      in   1      instruction memory data valid / ack
//   i_DmemReady      in   1      data memory ack (load data valid / store done)
//   o_ImemReq        out  1      instruction fetch request
//   o_DmemReq        out  1      data access request
//   o_DmemWe         out  1      1 = store, 0 = load; qualified by o_DmemReq
//   o_IRWrite        out  1      latch imem data into IR
//   o_PCWrite        out  1      update PC this cycle
//   o_PCSel          out  1      0 = PC+4, 1 = o_JumpBranchAddr_32
//   o_ALUSrc1Sel_2   out  2      0 = rs1, 1 = PC, 2 = zero
//   o_ALUSrc2Sel_2   out  2      0 = rs2, 1 = imm, 2 = const 4
//   o_RegWrite       out  1      regfile write enable
//   o_WBSel_2        out  2      0 = ALU result, 1 = load data, 2 = PC+4
//   o_Trap           out  1      sticky: core halted
//   o_TrapCause_2    out  2      0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout
//   o_State_3        out  3      current FSM state (debug)
//   o_InstRet_CNT    out  CNT_W  retired-instruction count
// BEHAVIOUR
//   - Reset (async, any time, mid-handshake included): state IDLE, all outputs 0, timer 0, counter 0.
//   - States: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=7. IDLE -> FETCH unconditionally next cycle.
//   - FETCH: o_ImemReq=1 until i_ImemReady; in ready cycle o_IRWrite=1 (1-cycle pulse), -> DECODE.
//   - DECODE: opcode=i_Inst_32[6:0]. Legal: 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR,
//     1100011 BRANCH, 0000011 LOAD, 0100011 STORE, 0010011 OP-IMM, 0110011 OP, 0001111 FENCE.
//     Any other (incl. 1110011 SYSTEM) -> TRAP cause 1; else -> EXEC. Opcode class registered here.
//   - EXEC selects: OP rs1/rs2; OP-IMM,LOAD,STORE,JALR rs1/imm; LUI zero/imm; AUIPC,JAL,BRANCH PC/imm.
//     BRANCH: o_PCWrite=1, o_PCSel=i_BranchTaken, retire, -> FETCH. FENCE: PCWrite PC+4, retire, -> FETCH.
//     LOAD/STORE -> MEM. Others -> WB.
//   - MEM: o_DmemReq=1, o_DmemWe=(STORE), selects held as in EXEC, until i_DmemReady.
//     STORE on ready: PCWrite PC+4, retire, -> FETCH. LOAD on ready -> WB.
//   - WB: o_RegWrite=1 unless rd=i_Inst_32[11:7]==0; WBSel: LOAD=1, JAL/JALR=2, else 0.
//     o_PCWrite=1, o_PCSel=1 for JAL/JALR else 0; retire; -> FETCH.
//   - Selects/WBSel are 0 outside EXEC/MEM/WB; all enables combinational from state, single-cycle.
//   - Latency (zero-wait memory): ALU/LUI/AUIPC/JAL/JALR 4 cycles, BRANCH/FENCE 3, STORE 4, LOAD 5.
//   - Timeout: wait timer clears on state entry, increments each FETCH/MEM cycle without ready;
//     ready arriving on the cycle the timer equals MEM_TIMEOUT-1 is accepted; no ready then
//     -> TRAP next cycle, cause 2 (FETCH) or 3 (MEM); request drops on entering TRAP.
//   - TRAP: all requests/enables 0, o_Trap=1, cause held; exit only via rst.
//   - Retire: o_InstRet_CNT +1 in the retiring cycle; wraps 2^CNT_W-1 -> 0 silently.
//   - Ready inputs ignored in states not waiting on them (late ack after a timeout is dropped).
// TESTING
//   - ADDI x1,x0,5 (0x00500093), zero-wait: states 1,2,3,5 -> RegWrite=1 in WB, WBSel=0, count 0->1.
//   - LW x2,0(x1) with dmem ready after 3 wait cycles: DmemReq high 4 cycles, WBSel=1, total 8 cycles.
//   - BEQ taken (i_BranchTaken=1): PCWrite=1, PCSel=1 in EXEC, no RegWrite, back to FETCH after 3 cycles.
//   - Opcode 0x73 (ECALL) -> o_Trap=1, cause=1, no further ImemReq for 20 cycles; rst restores IDLE.
//   - Imem ready never asserted: TRAP cause 2 exactly MEM_TIMEOUT cycles after FETCH entry; ready
//     at timer=MEM_TIMEOUT-1 instead -> accepted, no trap.
//   - Assert rst during MEM of a store: all outputs 0 immediately, counter 0, no PCWrite; CNT_W=4 wrap 15->0.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB control,
// bus timeouts, illegal-opcode trap and retired-instruction counter.
module mc_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      i_Inst_32,
  input  logic             i_BranchTaken,
  input  logic             i_ImemReady,
  input  logic             i_DmemReady,
  output logic             o_ImemReq,
  output logic             o_DmemReq,
  output logic             o_DmemWe,
  output logic             o_IRWrite,
  output logic             o_PCWrite,
  output logic             o_PCSel,
  output logic [1:0]       o_ALUSrc1Sel_2,
  output logic [1:0]       o_ALUSrc2Sel_2,
  output logic             o_RegWrite,
  output logic [1:0]       o_WBSel_2,
  output logic             o_Trap,
  output logic [1:0]       o_TrapCause_2,
  output logic [2:0]       o_State_3,
  output logic [CNT_W-1:0] o_InstRet_CNT
);

  localparam int TW = $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_LUI, C_AUIPC, C_JAL, C_JALR, C_BR,
    C_LD, C_ST, C_OPI, C_OP, C_FENCE
  } cls_t;

  state_t          state;
  cls_t            cls;
  cls_t            dec_cls;
  logic            dec_ok;
  logic [TW-1:0]   timer;
  logic [1:0]      cause;
  logic [CNT_W-1:0] cnt;
  logic            retire;
  logic [1:0]      sel1;
  logic [1:0]      sel2;
  logic            is_jump;
  logic            unused_inst;

  assign unused_inst = ^i_Inst_32[31:12];
  assign is_jump     = (cls == C_JAL) || (cls == C_JALR);

  always_comb begin
    dec_ok  = 1'b1;
    dec_cls = C_OP;
    case (i_Inst_32[6:0])
      7'b0110111: dec_cls = C_LUI;
      7'b0010111: dec_cls = C_AUIPC;
      7'b1101111: dec_cls = C_JAL;
      7'b1100111: dec_cls = C_JALR;
      7'b1100011: dec_cls = C_BR;
      7'b0000011: dec_cls = C_LD;
      7'b0100011: dec_cls = C_ST;
      7'b0010011: dec_cls = C_OPI;
      7'b0110011: dec_cls = C_OP;
      7'b0001111: dec_cls = C_FENCE;
      default:    dec_ok  = 1'b0;
    endcase
  end

  always_comb begin
    sel1 = 2'd0;
    sel2 = 2'd0;
    case (cls)
      C_OPI, C_LD, C_ST, C_JALR: sel2 = 2'd1;
      C_LUI: begin
        sel1 = 2'd2;
        sel2 = 2'd1;
      end
      C_AUIPC, C_JAL, C_BR: begin
        sel1 = 2'd1;
        sel2 = 2'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_ImemReq      = 1'b0;
    o_IRWrite      = 1'b0;
    o_DmemReq      = 1'b0;
    o_DmemWe       = 1'b0;
    o_PCWrite      = 1'b0;
    o_PCSel        = 1'b0;
    o_ALUSrc1Sel_2 = 2'd0;
    o_ALUSrc2Sel_2 = 2'd0;
    o_RegWrite     = 1'b0;
    o_WBSel_2      = 2'd0;
    o_Trap         = 1'b0;
    retire         = 1'b0;
    case (state)
      S_FETCH: begin
        o_ImemReq = 1'b1;
        o_IRWrite = i_ImemReady;
      end
      S_EXEC: begin
        o_ALUSrc1Sel_2 = sel1;
        o_ALUSrc2Sel_2 = sel2;
        if (cls == C_BR) begin
          o_PCWrite = 1'b1;
          o_PCSel   = i_BranchTaken;
          retire    = 1'b1;
        end else if (cls == C_FENCE) begin
          o_PCWrite = 1'b1;
          retire    = 1'b1;
        end
      end
      S_MEM: begin
        o_ALUSrc1Sel_2 = sel1;
        o_ALUSrc2Sel_2 = sel2;
        o_DmemReq      = 1'b1;
        o_DmemWe       = (cls == C_ST);
        if (i_DmemReady && cls == C_ST) begin
          o_PCWrite = 1'b1;
          retire    = 1'b1;
        end
      end
      S_WB: begin
        o_ALUSrc1Sel_2 = sel1;
        o_ALUSrc2Sel_2 = sel2;
        o_RegWrite     = |i_Inst_32[11:7];
        o_WBSel_2      = (cls == C_LD) ? 2'd1 :
                         is_jump       ? 2'd2 : 2'd0;
        o_PCWrite      = 1'b1;
        o_PCSel        = is_jump;
        retire         = 1'b1;
      end
      S_TRAP: o_Trap = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cls   <= C_OP;
      timer <= '0;
      cause <= 2'd0;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(retire);
      case (state)
        S_IDLE: begin
          state <= S_FETCH;
          timer <= '0;
        end
        S_FETCH: begin
          if (i_ImemReady) begin
            state <= S_DECODE;
            timer <= '0;
          end else if (timer == T_LAST) begin
            state <= S_TRAP;
            cause <= 2'd2;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_DECODE: begin
          if (dec_ok) begin
            cls   <= dec_cls;
            state <= S_EXEC;
          end else begin
            state <= S_TRAP;
            cause <= 2'd1;
          end
        end
        S_EXEC: begin
          timer <= '0;
          case (cls)
            C_BR, C_FENCE: state <= S_FETCH;
            C_LD, C_ST:    state <= S_MEM;
            default:       state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (i_DmemReady) begin
            state <= (cls == C_ST) ? S_FETCH : S_WB;
            timer <= '0;
          end else if (timer == T_LAST) begin
            state <= S_TRAP;
            cause <= 2'd3;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_WB: begin
          state <= S_FETCH;
          timer <= '0;
        end
        S_TRAP: state <= S_TRAP;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_TrapCause_2 = cause;
  assign o_State_3     = state;
  assign o_InstRet_CNT = cnt;

endmodule
